// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the 8N1 receiver.
// master is the receiver itself; slave is the pin driver / byte consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       data_flag;
  logic       frame_err;

  modport master (input rx, output data, output data_flag, output frame_err);
  modport slave  (output rx, input data, input data_flag, input frame_err);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised rx, mid-bit sampling, one-cycle byte and
// framing-error strobes.
//
// state | meaning
// IDLE  | line idle, baud_cnt held at 0, waiting for a falling edge
// START | timing to mid start bit; a high sample there is a glitch
// DATA  | sampling 8 data bits LSB first, one per BAUD_CNT clocks
// STOP  | sampling the stop bit; high -> byte out, low -> frame error
// BREAK | line held low after a bad stop bit; wait for it to go high
module uart_rx #(
  parameter int BAUD    = 9600,
  parameter int CLK_FRE = 50_000_000
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.master bus
);

  localparam int BAUD_CNT = CLK_FRE / BAUD;
  localparam int HALF_CNT = BAUD_CNT / 2;
  localparam int CNT_W    = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t           state;
  logic             rx_s1, rx_s2, rx_s3;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic [7:0]       data_q;
  logic             flag_q;
  logic             err_q;

  logic start_edge;
  logic sample;
  logic baud_wrap;

  assign start_edge = rx_s3 & ~rx_s2;
  assign sample     = (baud_cnt == CNT_W'(HALF_CNT - 1));
  assign baud_wrap  = (baud_cnt == CNT_W'(BAUD_CNT - 1));

  assign bus.data      = data_q;
  assign bus.data_flag = flag_q;
  assign bus.frame_err = err_q;

  // Reset to idle level so releasing reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= bus.rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      data_q   <= 8'h00;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;

      if (state == IDLE || baud_wrap)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          bit_cnt <= 3'd0;
          if (start_edge)
            state <= START;
        end
        START: begin
          if (sample)
            state <= rx_s2 ? IDLE : DATA;
        end
        DATA: begin
          if (sample) begin
            shift[bit_cnt] <= rx_s2;
            bit_cnt        <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= STOP;
          end
        end
        // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
        STOP: begin
          if (sample) begin
            if (rx_s2) begin
              data_q <= shift;
              flag_q <= 1'b1;
              state  <= IDLE;
            end else begin
              err_q <= 1'b1;
              state <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s2)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a line driver pushes expected strobes per frame,
// a negedge monitor pops and compares data, kind and latency.
module tb_uart_rx;

  localparam int TB_BAUD = 1_000_000;
  localparam int TB_CLK  = 50_000_000;
  localparam int CLK_NS  = 20;
  localparam int BC      = TB_CLK / TB_BAUD;
  localparam int HC      = BC / 2;
  localparam int BIT_NS  = BC * CLK_NS;
  localparam int LAT     = 9 * BC + HC + 3;

  typedef struct {
    logic [7:0] b;
    longint     t0;
    bit         chk_lat;
    bit         is_err;
  } exp_t;

  logic clk;
  logic rst_n;
  uart_rx_if u_if ();

  uart_rx #(.BAUD(TB_BAUD), .CLK_FRE(TB_CLK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         stab_viol = 0;
  logic [7:0] model_data = 8'h00;

  initial clk = 1'b0;
  always #(CLK_NS / 2) clk = ~clk;

  // Monitor: compares every strobe against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t   e;
    longint lat;
    if (!rst_n) begin
      model_data = 8'h00;
    end else if (u_if.data_flag || u_if.frame_err) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: flag=%0b err=%0b data=%02h, required no strobe",
                 u_if.data_flag, u_if.frame_err, u_if.data);
      end else begin
        e = sb.pop_front();
        if (u_if.data_flag !== !e.is_err || u_if.frame_err !== e.is_err) begin
          errors++;
          $display("FAIL strobe_kind: flag=%0b err=%0b, required flag=%0b err=%0b",
                   u_if.data_flag, u_if.frame_err, !e.is_err, e.is_err);
        end
        checks++;
        if (!e.is_err) begin
          if (u_if.data !== e.b) begin
            errors++;
            $display("FAIL rx_data: got %02h, required %02h", u_if.data, e.b);
          end
          model_data = e.b;
        end else if (u_if.data !== model_data) begin
          errors++;
          $display("FAIL data_hold_on_err: got %02h, required %02h", u_if.data, model_data);
        end
        if (e.chk_lat) begin
          lat = (longint'($time) - e.t0) / CLK_NS;
          checks++;
          if (lat < LAT - 2 || lat > LAT + 2) begin
            errors++;
            $display("FAIL latency: got %0d clocks, required %0d +/-2", lat, LAT);
          end
        end
      end
    end else if (u_if.data !== model_data) begin
      stab_viol++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [7:0] b, input bit stop_val, input int bit_ns);
    u_if.rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = b[i];
      #(bit_ns);
    end
    u_if.rx = stop_val;
    #(bit_ns);
  endtask

  task automatic align();
    @(posedge clk);
    #3;
  endtask

  // Push the expected outcome, then put the frame on the line.
  task automatic tx(input logic [7:0] b, input bit stop_ok, input int bit_ns, input bit chk_lat);
    sb.push_back('{b, longint'($time), chk_lat, !stop_ok});
    send_frame(b, stop_ok, bit_ns);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 3 * LAT) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: pending=%0d, required 0", name, sb.size());
      sb.delete();
    end
    #(2 * BIT_NS);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (u_if.data !== 8'h00 || u_if.data_flag !== 1'b0 || u_if.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: data=%02h flag=%0b err=%0b, required 00/0/0",
               name, u_if.data, u_if.data_flag, u_if.frame_err);
    end
  endtask

  initial begin
    logic [7:0] rb;
    int         dev;
    int         bit_ns;
    int         gap;
    bit         bad;

    u_if.rx = 1'b1;
    rst_n   = 1'b0;
    #105;
    @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("post_reset_idle");

    // Single frame
    align();
    tx(8'h55, 1'b1, BIT_NS, 1'b1);
    drain("0x55");

    // Paced bytes 0..4
    for (int i = 0; i < 5; i++) begin
      align();
      tx(8'(i), 1'b1, BIT_NS, 1'b1);
      #(3 * BIT_NS);
    end
    drain("seq");

    // Back-to-back frames, no idle in between
    align();
    tx(8'hA5, 1'b1, BIT_NS, 1'b1);
    tx(8'h3C, 1'b1, BIT_NS, 1'b1);
    drain("b2b");

    // Short low glitch, then a real frame
    align();
    u_if.rx = 1'b0;
    #(10 * CLK_NS);
    u_if.rx = 1'b1;
    #(2 * BIT_NS);
    align();
    tx(8'h81, 1'b1, BIT_NS, 1'b1);
    drain("glitch");

    // Bad stop bit followed by a held-low line
    align();
    tx(8'hF0, 1'b0, BIT_NS, 1'b1);
    #(3 * BIT_NS);
    u_if.rx = 1'b1;
    #(2 * BIT_NS);
    align();
    tx(8'h0F, 1'b1, BIT_NS, 1'b1);
    drain("break");

    // Reset during data bit 4; the partial frame must vanish
    fork
      begin
        align();
        send_frame(8'hFF, 1'b1, BIT_NS);
      end
      begin
        #(5 * BIT_NS + BIT_NS / 2);
        rst_n = 1'b0;
        #100;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_frame_reset");
      end
    join
    #(2 * BIT_NS);
    align();
    tx(8'h12, 1'b1, BIT_NS, 1'b1);
    drain("after_reset");

    // Random bytes, gaps, +/-2% baud and occasional bad stop bits
    for (int k = 0; k < 20; k++) begin
      rb     = 8'($urandom);
      dev    = int'($urandom_range(0, 4));
      bit_ns = BIT_NS * (98 + dev) / 100;
      bad    = ($urandom_range(0, 7) == 0);
      gap    = int'($urandom_range(0, 3));
      align();
      tx(rb, !bad, bit_ns, dev == 2);
      if (bad) begin
        #(2 * bit_ns);
        u_if.rx = 1'b1;
        #(bit_ns);
      end
      #(gap * bit_ns);
    end
    drain("random");

    checks++;
    if (stab_viol != 0) begin
      errors++;
      $display("FAIL data_stability: %0d cycles changed without strobe, required 0", stab_viol);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
